mmio_uart_tx: RTL

Memory-mapped console transmitter on the single-cycle core's data-memory write bus (MemWrite / DataAdr / WriteData). Bytes the program stores to its data register are queued in a small FIFO and shifted out as 8N1 serial frames. A status register reports FIFO and transmitter state, so firmware can poll before writing. This is the receiving end of the core's store traffic: it consumes the writes the core issues, alongside data memory.

---
 rtl/mmio_uart_tx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 console transmitter with byte FIFO and status register
//
// Ports:
//   clk        core clock, all state on rising edge
//   reset      asynchronous active-high reset
//   MemWrite   store strobe from core
//   DataAdr    store/load address from core
//   WriteData  store data from core (TXDATA uses [7:0], STATUS clear uses [3])
//   ReadData   STATUS when DataAdr==BASE_ADDR+4, else 0 (combinational)
//   tx         serial line, idle high
//   busy       FSM not IDLE or FIFO non-empty
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shift, shift_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          ovf;

    logic wr_data, wr_stat, full, empty, pop, push, ovf_set, ovf_clr;
    logic [31:0] status;

    // Only the low byte of a TXDATA store is meaningful.
    logic unused_wdata;
    assign unused_wdata = ^WriteData[31:8];

    assign wr_data = MemWrite && (DataAdr == BASE_ADDR);
    assign wr_stat = MemWrite && (DataAdr == BASE_ADDR + 32'd4);
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign push    = wr_data && (!full || pop);
    assign ovf_set = wr_data && full && !pop;
    assign ovf_clr = wr_stat && WriteData[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            // Set has priority over a same-cycle clear.
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        tx       = 1'b1;
        case (state)
            IDLE: begin
                tx = 1'b1;
                if (pop) begin
                    state_n  = START;
                    shift_n  = mem[rptr];
                    bitcnt_n = '0;
                    baud_n   = '0;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud == BAUD_LAST) begin
                    state_n = DATA;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                tx = shift[0];
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        shift_n  = shift >> 1;
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                tx = 1'b1;
                if (baud == BAUD_LAST) begin
                    state_n = IDLE;
                    baud_n  = '0;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE) || !empty;

    always_comb begin
        status           = '0;
        status[0]        = full;
        status[1]        = empty;
        status[2]        = (state != IDLE);
        status[3]        = ovf;
        status[8 +: AW+1] = count;
    end

    assign ReadData = (DataAdr == BASE_ADDR + 32'd4) ? status : 32'h0;

endmodule
